// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Optional phase-sync input is compiled in with CLK_DIV_PHASE_SYNC_EN.
package clk_div_pkg;

  localparam int DIV_W_DEF = 21;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, double-buffered divisor, square wave and rise tick.
// CLK_DIV_PHASE_SYNC_EN adds the sync input (clear phase, apply pending now).
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLK_DIV_PHASE_SYNC_EN
  input  logic             sync,
`endif
  output logic             clkout,
  output logic             rise_tick,
  output logic             pend
);

  logic [DIV_W-1:0] cnt, act, pnd;
  logic [DIV_W-1:0] cnt_n, act_n, pnd_n, eff_d;
  logic             clk_n, pend_n, run, run_q, load;

  always_comb begin
    // A divisor left pending while disabled is taken on the first enabled edge.
    load   = ~run_q & pend;
    eff_d  = load ? pnd : act;
    run    = en && (eff_d != '0);
    cnt_n  = cnt;
    act_n  = act;
    pnd_n  = pnd;
    pend_n = pend;
    clk_n  = clkout;
    if (!run) begin
      cnt_n = '0;
      clk_n = 1'b0;
      if (en && load) begin
        act_n  = pnd;
        pend_n = 1'b0;
      end
      if (wr) begin
        act_n  = wr_div;
        pend_n = 1'b0;
      end
    end
`ifdef CLK_DIV_PHASE_SYNC_EN
    else if (sync) begin
      cnt_n  = '0;
      clk_n  = 1'b0;
      act_n  = wr ? wr_div : (pend ? pnd : act);
      pend_n = 1'b0;
    end
`endif
    else begin
      act_n  = eff_d;
      pend_n = pend & ~load;
      if (cnt < eff_d - DIV_W'(1)) begin
        cnt_n = cnt + DIV_W'(1);
      end else begin
        cnt_n = '0;
        if (pend_n) begin
          // Switching to D=0 parks the output low instead of toggling.
          act_n  = pnd;
          pend_n = 1'b0;
          clk_n  = (pnd != '0) & ~clkout;
        end else begin
          clk_n = ~clkout;
        end
      end
      if (wr) begin
        pnd_n  = wr_div;
        pend_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (!rstn) begin
      cnt       <= '0;
      act       <= DIV_RST;
      pnd       <= DIV_RST;
      pend      <= 1'b0;
      clkout    <= 1'b0;
      rise_tick <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      act       <= act_n;
      pnd       <= pnd_n;
      pend      <= pend_n;
      clkout    <= clk_n;
      rise_tick <= clk_n & ~clkout;
      run_q     <= run;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NCH-channel programmable clock divider for the sound path.
// CLK_DIV_PHASE_SYNC_EN adds a global sync input that phase-aligns all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RST = '0,
  localparam int              CH_W    = ch_w(NCH)
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic [NCH-1:0]   en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLK_DIV_PHASE_SYNC_EN
  input  logic             sync,
`endif
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   rise_tick,
  output logic [NCH-1:0]   pend
);

  logic [NCH-1:0] wr_sel;

  // Out-of-range selects match no lane and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++)
      wr_sel[i] = wr_en && (32'(wr_ch) == 32'(i));
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clkin     (clkin),
      .rstn      (rstn),
      .en        (en[i]),
      .wr        (wr_sel[i]),
      .wr_div    (wr_div),
`ifdef CLK_DIV_PHASE_SYNC_EN
      .sync      (sync),
`endif
      .clkout    (clkout[i]),
      .rise_tick (rise_tick[i]),
      .pend      (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (NCH=5 so an out-of-range select exists).
module tb_clk_div_multi;

  localparam int NCH = 5;

  logic           clkin = 1'b0;
  logic           rstn;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [2:0]     wr_ch;
  logic [20:0]    wr_div;
  logic           sync;
  logic [NCH-1:0] clkout, rise_tick, pend;

  int vectors = 0;
  int miscompares = 0;

  always #5 clkin = ~clkin;

  clk_div_multi #(.NCH(NCH), .DIV_W(21), .DIV_RST(21'd0)) dut (
    .clkin     (clkin),
    .rstn      (rstn),
    .en        (en),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_div    (wr_div),
`ifdef CLK_DIV_PHASE_SYNC_EN
    .sync      (sync),
`endif
    .clkout    (clkout),
    .rise_tick (rise_tick),
    .pend      (pend)
  );

  task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed %0h expected %0h", tag, j, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clkin);
    #1;
    wr_en = 1'b0;
  endtask

  // Load d0 into an idle channel, then run n edges, optionally writing wr_val
  // before edge wr_at; bit j-1 of ec/et/ep is the expected value after edge j.
  task automatic run_trace(input int ch, input int d0, input int n, input int wr_at,
                           input int wr_val, input logic [31:0] ec,
                           input logic [31:0] et, input logic [31:0] ep);
    wr_en = 1'b1; wr_ch = 3'(ch); wr_div = 21'(d0);
    edge1();
    chk("load_pend", ch, 32'(pend[ch]), 32'd0);
    for (int j = 1; j <= n; j++) begin
      if (j == wr_at) begin
        wr_en = 1'b1; wr_ch = 3'(ch); wr_div = 21'(wr_val);
      end
      edge1();
      chk("clkout", j, 32'(clkout[ch]), 32'(ec[j-1]));
      chk("rise_tick", j, 32'(rise_tick[ch]), 32'(et[j-1]));
      chk("pend", j, 32'(pend[ch]), 32'(ep[j-1]));
    end
  endtask

  initial begin
    rstn = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync = 1'b0;
    edge1();
    edge1();
    chk("rst_clkout", 0, 32'(clkout), 32'd0);
    chk("rst_tick", 0, 32'(rise_tick), 32'd0);
    chk("rst_pend", 0, 32'(pend), 32'd0);

    rstn = 1'b1; en = '1;
    edge1();
    chk("idle_clkout", 0, 32'(clkout), 32'd0);

    // ch0 D=3: rise 3 edges after load, period 6
    run_trace(0, 3, 12, 0, 0, 32'h71C, 32'h104, 32'h0);
    chk("others_idle", 0, 32'(clkout[4:1]), 32'd0);

    // ch1 D=4, write D=2 while cnt=1: current half stays 4, then 2
    run_trace(1, 4, 14, 6, 2, 32'h2678, 32'h2208, 32'h60);

    // ch2 D=5, write 7 on the boundary edge: 7 applies one boundary later
    run_trace(2, 5, 17, 5, 7, 32'h0001_01F0, 32'h0001_0010, 32'h1F0);

    // ch3 D=2, write D=0 before a rising boundary: parks low, no tick
    run_trace(3, 2, 10, 5, 0, 32'h6, 32'h2, 32'h10);
    // ch3 now idle: D=1 loads immediately, clkin/2
    run_trace(3, 1, 6, 0, 0, 32'h15, 32'h15, 32'h0);

    // out-of-range selects must not alias onto running channels
    wr_en = 1'b1; wr_ch = 3'd5; wr_div = 21'd3;
    edge1();
    chk("oor5_pend", 0, 32'(pend), 32'd0);
    wr_en = 1'b1; wr_ch = 3'd7; wr_div = 21'd3;
    edge1();
    chk("oor7_pend", 0, 32'(pend), 32'd0);
    for (int j = 1; j <= 6; j++) begin
      edge1();
      chk("oor_ch4", j, 32'(clkout[4]), 32'd0);
    end

    // reset mid-operation overrides a concurrent write
    rstn = 1'b0; wr_en = 1'b1; wr_ch = 3'd4; wr_div = 21'd5;
    edge1();
    chk("mrst_clkout", 0, 32'(clkout), 32'd0);
    chk("mrst_tick", 0, 32'(rise_tick), 32'd0);
    chk("mrst_pend", 0, 32'(pend), 32'd0);
    rstn = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      edge1();
      chk("post_rst", j, 32'(clkout), 32'd0);
    end

`ifdef CLK_DIV_PHASE_SYNC_EN
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 21'd3;
    edge1();
    wr_en = 1'b1; wr_ch = 3'd1; wr_div = 21'd6;
    edge1();
    edge1();
    edge1();
    sync = 1'b1;
    edge1();
    sync = 1'b0;
    chk("sync_clr", 0, 32'(clkout[1:0]), 32'd0);
    edge1();
    edge1();
    chk("sync_s2", 2, 32'(clkout[1:0]), 32'd0);
    edge1();
    chk("sync_s3", 3, 32'(clkout[1:0]), 32'd1);
    chk("sync_t3", 3, 32'(rise_tick[1:0]), 32'd1);
    edge1();
    edge1();
    chk("sync_s5", 5, 32'(clkout[1:0]), 32'd1);
    edge1();
    chk("sync_s6", 6, 32'(clkout[1:0]), 32'd2);
    chk("sync_t6", 6, 32'(rise_tick[1:0]), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel successor to the single-channel divider, used in the sound path to derive tone and bit clocks from clkin.
- NCH independent channels. Each has a runtime-programmable half-period divisor, a per-channel enable, a registered square-wave output and a one-cycle rising-edge tick.
- Divisor updates are double-buffered and applied only at a half-period boundary, so changing the pitch never produces a glitch.

Parameters:
- NCH, 4, number of channels (1..16)
- DIV_W, 21, divisor width in bits
- DIV_RST, 0, active and pending divisor value after reset (0 = channel silent)

Ports:
- clkin  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- en  in  NCH  per-channel run enable
- wr_en  in  1  divisor write strobe, one cycle
- wr_ch  in  CH_W  target channel; CH_W = max(1, $clog2(NCH))
- wr_div  in  DIV_W  new half-period divisor D
- clkout  out  NCH  divided square wave, registered
- rise_tick  out  NCH  one-cycle pulse in the cycle clkout goes 0->1
- pend  out  NCH  a written divisor is waiting for the next boundary

Behaviour:
- Reset (rstn low at a clkin edge):
  - clkout, rise_tick and pend are 0.
  - cnt is 0.
  - Active and pending divisors are DIV_RST.
- A channel is idle when en is 0 or active D is 0. While idle:
  - cnt is held at 0.
  - clkout is 0 at the next edge; rise_tick stays 0.
- Running channel, active D >= 1:
  - Each edge: if cnt < D-1, cnt increments; otherwise cnt <= 0 and clkout toggles (this is the boundary).
  - Output period is 2*D clkin cycles with 50% duty. D=1 gives clkin/2.
- Start-up: the first clkout rise occurs D edges after the first edge that samples en=1 with D>=1.
- rise_tick is asserted exactly in the cycle clkout registers 1. It is never asserted on a fall.
- Writes:
  - wr_en with wr_ch >= NCH is ignored.
  - Otherwise, to a running channel: pending <= wr_div and pend <= 1.
  - At the channel's next boundary: active <= pending, pend <= 0, and the new D governs the following half-period.
  - Last write wins: repeated writes before the boundary overwrite the pending value.
- Write to an idle channel: active <= wr_div directly at that edge; pend stays 0.
- Write coinciding with a boundary on the same channel:
  - The boundary applies the pending value held before that edge.
  - The new value becomes pending and pend stays 1.
- Writing D=0 to a running channel: applied at the boundary, after which the channel is idle and clkout is driven to 0.
- en deasserted mid-period: cnt and clkout clear next edge; pending is retained and applied on re-enable at the first edge.
- cnt is DIV_W bits wide. Comparison is unsigned against D-1, and is evaluated only when D >= 1, so there is no wrap.
- Reset mid-operation overrides all other events in that cycle.

Optional Feature:
- CLK_DIV_PHASE_SYNC_EN defined:
  - Adds input sync (1 bit).
  - When sync is 1 at an edge, every running channel clears cnt to 0 and clkout to 0, and applies any pending divisor immediately.
  - All channels are thus phase-aligned from the next edge. sync takes priority over boundary and write-to-pending in that cycle.
- Not defined: sync port is absent and channels free-run independently.

Decomposition:
- Package clk_div_pkg holds:
  - DIV_W_DEF = 21
  - typedef div_t (logic [DIV_W-1:0], default width)
  - function ch_w(nch) computing CH_W
- Sub-module clk_div_ch: one channel (cnt, active/pending registers, clkout, rise_tick, pend). It takes a decoded per-channel write strobe and, with the feature compiled in, sync.
- Top level does the wr_ch decode and generates NCH instances.

Test Plan:
- Reset then en=1, write D=3 to ch0 (idle) -> clkout[0] rises 3 edges after write, period 6; rise_tick[0] one cycle per period; other channels stay 0.
- ch1 running D=4, write D=2 at cnt=1 -> pend[1]=1 until boundary; current half-period stays 4, then 2 onward; no pulse shorter than 2 cycles.
- Write at exact boundary cycle of ch2 (D=5 -> 7) -> boundary applies old pending (none; D stays 5); 7 applied at following boundary; pend high in between.
- Write D=0 to running ch3 -> after boundary clkout[3]=0, no ticks; rewrite D=1 -> immediate load, clkin/2 output.
- wr_ch=NCH (out of range), and rstn low mid-period -> write ignored; rstn clears all outputs and pend at the next edge; divisors return to DIV_RST.
- CLK_DIV_PHASE_SYNC_EN: ch0 D=3, ch1 D=6, pulse sync -> both clkout=0 and cnt=0 next edge; ch0 rises 3 edges later, ch1 6 edges later.
